// File: rtl/pixel_pkg.sv
// Shared constants, types and scan-state encoding for clients of the pixel SRAM.
package pixel_pkg;

  localparam int PIXEL_COLUMN = 80;
  localparam int PIXEL_ROW    = 60;
  localparam int PIXEL_NUM    = PIXEL_COLUMN * PIXEL_ROW;

  localparam int ADDR_W  = 13;
  localparam int PIXEL_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/frame_scan_reader_raster_counter.sv
// Raster-order fetch position: column, row and a separately incremented SRAM address.
module raster_counter #(
  parameter int              COLS      = 80,
  parameter int              ROWS      = 60,
  parameter int              AW        = 13,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          clear,
  output logic [6:0]    col,
  output logic [5:0]    row,
  output logic [AW-1:0] addr,
  output logic          line_end,
  output logic          last
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  assign line_end = (col == COL_LAST);
  assign last     = line_end && (row == ROW_LAST);

  // NOTE: state uses non-blocking assignments under an async active-low reset;
  // blocking here would create order-dependent races between always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      addr <= BASE_ADDR;
    end else if (clear || (advance && last)) begin
      col  <= '0;
      row  <= '0;
      addr <= BASE_ADDR;
    end else if (advance) begin
      addr <= addr + 1'b1;
      if (line_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scan_reader.sv
// Scans the pixel SRAM in raster order and emits it as a valid/ready stream with coordinates and framing flags.
module frame_scan_reader
  import pixel_pkg::*;
#(
  parameter int            COLS      = PIXEL_COLUMN,
  parameter int            ROWS      = PIXEL_ROW,
  parameter int            AW        = ADDR_W,
  parameter int            DW        = PIXEL_W,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [6:0]    o_col,
  output logic [5:0]    o_row,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_frame_cnt
);

  scan_state_t state;

  logic [6:0] cnt_col;
  logic [5:0] cnt_row;
  logic       cnt_line_end;
  logic       cnt_last;
  logic       load;
  logic       accept;

  assign load   = (state == SCAN) && (!o_valid || i_ready);
  assign accept = o_valid && i_ready;
  assign o_busy = (state != IDLE);

  // NOTE: o_done is combinational so it coincides with the accept of the last
  // pixel; an abort in that same cycle suppresses it.
  assign o_done = (state == DRAIN) && accept && !i_abort;

  raster_counter #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .AW        (AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_raster (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .advance  (load && !i_abort),
    .clear    (i_abort),
    .col      (cnt_col),
    .row      (cnt_row),
    .addr     (o_rd_addr),
    .line_end (cnt_line_end),
    .last     (cnt_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_col       <= '0;
      o_row       <= '0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_eof       <= 1'b0;
      o_frame_cnt <= '0;
    end else if (i_abort) begin
      state   <= IDLE;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (i_start) state <= SCAN;
        SCAN:    if (load && cnt_last) state <= DRAIN;
        DRAIN: begin
          if (accept) begin
            state       <= IDLE;
            o_frame_cnt <= o_frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register: reload when empty or draining, otherwise hold under backpressure.
      if (load) begin
        o_valid <= 1'b1;
        o_data  <= i_rd_data;
        o_col   <= cnt_col;
        o_row   <= cnt_row;
        o_sof   <= (cnt_col == '0) && (cnt_row == '0);
        o_eol   <= cnt_line_end;
        o_eof   <= cnt_last;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
